bcd_conv_sched: RTL

Round-robin scheduler that shares one serial double-dabble binary-to-BCD engine among several requesters in the calculator: operand A entry, operand B entry and the ALU result. It captures a 32-bit unsigned value from the winning requester and runs the conversion over a fixed number of cycles. It then returns the packed BCD digits to the display path with a per-requester done pulse.

---
 rtl/calc_pkg.sv | 18 +
 rtl/bcd_dd_engine.sv | 49 ++++
 rtl/bcd_conv_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator types and constants: conversion FSM states, BCD sizing
// and the fixed requester indices of the binary-to-BCD scheduler.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam int BCD_DIGITS = 10;
  localparam int DD_ADD3_TH = 5;

  localparam int REQ_OPA = 0;
  localparam int REQ_OPB = 1;
  localparam int REQ_RES = 2;

endpackage

// File: rtl/bcd_dd_engine.sv
// Serial double-dabble datapath: the BCD field sits above the binary field in
// one shift register; each step corrects every nibble and shifts left by one.
module bcd_dd_engine
  import calc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                step,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int SW = WIDTH + 4 * DIGITS;

  logic [SW-1:0] sr_reg;
  logic [SW-1:0] adj;
  logic [SW-1:0] sr_next;

  assign adj[WIDTH-1:0] = sr_reg[WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      logic [3:0] nib;
      assign nib = sr_reg[WIDTH + 4*gi +: 4];
      assign adj[WIDTH + 4*gi +: 4] = (nib >= 4'(DD_ADD3_TH)) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign sr_next = adj << 1;

  // Exposes the post-step BCD field so the scheduler can register the result
  // on the same edge as the final step.
  assign bcd = sr_next[WIDTH +: 4*DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= {{(4*DIGITS){1'b0}}, load_val};
    end else if (step) begin
      sr_reg <= sr_next;
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one serial binary-to-BCD engine among the
// operand A, operand B and ALU result requesters.
module bcd_conv_sched
  import calc_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int WIDTH  = 32,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*WIDTH-1:0]     data_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           done_o,
  output logic [4*DIGITS-1:0]        bcd_o,
  output logic [$clog2(N_REQ)-1:0]   tag_o,
  output logic                       busy_o
);

  localparam int TW = $clog2(N_REQ);
  localparam int CW = $clog2(WIDTH + 1);

  // 10^DIGITS >= 2^WIDTH  <=>  DIGITS * log2(10) >= WIDTH
  generate
    if (longint'(DIGITS) * 64'sd3321928 < longint'(WIDTH) * 64'sd1000000) begin : g_bad_digits
      $error("bcd_conv_sched: DIGITS too small for WIDTH");
    end
  endgenerate

  conv_state_t       state_reg, state_next;
  logic [TW-1:0]     last_reg;
  logic [CW-1:0]     cnt_reg;
  logic [TW-1:0]     rr_pick;
  logic              rr_any;
  int                rr_idx;
  logic              load;
  logic              step;
  logic              last_step;
  logic [WIDTH-1:0]  load_val;
  logic [4*DIGITS-1:0] eng_bcd;

  // Scan from farthest to nearest offset so the nearest requester after last wins.
  always_comb begin
    rr_pick = last_reg;
    rr_any  = 1'b0;
    rr_idx  = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      rr_idx = (int'(last_reg) + 1 + i) % N_REQ;
      if (req_i[rr_idx]) begin
        rr_pick = TW'(rr_idx);
        rr_any  = 1'b1;
      end
    end
  end

  assign load_val  = data_i[int'(rr_pick)*WIDTH +: WIDTH];
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rr_any) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_o    <= '0;
      last_reg <= TW'(N_REQ - 1);
      cnt_reg  <= '0;
      bcd_o    <= '0;
      tag_o    <= '0;
    end else begin
      if (load) begin
        gnt_o    <= N_REQ'(1) << rr_pick;
        last_reg <= rr_pick;
        cnt_reg  <= '0;
      end
      if (step) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (last_step) begin
          bcd_o <= eng_bcd;
          tag_o <= last_reg;
        end
      end
      if (state_reg == DONE) gnt_o <= '0;
    end
  end

  // gnt_o is already the one-hot owner, so the done pulse reuses it.
  assign done_o = (state_reg == DONE) ? gnt_o : '0;
  assign busy_o = (state_reg != IDLE);

  bcd_dd_engine #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .bcd      (eng_bcd)
  );

endmodule
